// File: rtl/pe_col_drain_if.sv
// Downstream valid/ready stream carrying formatted drain words.
interface pe_col_drain_if #(
    parameter int OUT_WIDTH = 32,
    parameter int ROWS      = 16
);
    localparam int RW = $clog2(ROWS);

    logic                 m_valid;
    logic                 m_ready;
    logic [OUT_WIDTH-1:0] m_data;
    logic [RW-1:0]        m_row;
    logic                 m_last;

    modport master (
        output m_valid, m_data, m_row, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_row, m_last,
        output m_ready
    );
endinterface

// File: rtl/pe_col_drain.sv
// Systolic column drain: grant, row tagging, int/fp formatting, output FIFO.
// Optional macro PE_COL_DRAIN_SAT_EN: saturating int narrowing.
module pe_col_drain #(
    parameter int ROWS       = 16,
    parameter int IN_WIDTH   = 48,
    parameter int OUT_WIDTH  = 32,
    parameter int SHIFT      = 0,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode_sel_in,
    input  logic                drain_req_in,
    output logic                drain_gnt_out,
    input  logic                col_vld_in,
    input  logic [IN_WIDTH-1:0] col_in,
    output logic                err_out,
    input  logic                err_clr_in,
    pe_col_drain_if.master      dn
);
    localparam int RW = $clog2(ROWS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = OUT_WIDTH + RW + 1;
    localparam logic [RW-1:0] ROWS_M1 = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        COLLECT
    } state_t;

    state_t        state;
    logic [RW-1:0] cnt;
    logic [1:0]    mode_q;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   mem_cnt;
    logic [AW+1:0] occ;
    logic          head_vld;
    logic [EW-1:0] head;

    logic                 push;
    logic                 stray;
    logic                 pop;
    logic                 load;
    logic                 room;
    logic                 is_fp;
    logic                 sat_hit;
    logic [OUT_WIDTH-1:0] fmt;
    logic [RW-1:0]        row;
    logic [EW-1:0]        entry;

    assign push    = col_vld_in && (state == COLLECT);
    assign stray   = col_vld_in && (state != COLLECT);
    assign pop     = head_vld && dn.m_ready;
    assign mem_cnt = wr_ptr - rd_ptr;
    assign load    = (mem_cnt != '0) && (!head_vld || pop);

    // Head register counts toward capacity; a same-cycle pop frees its slot.
    assign occ  = {1'b0, mem_cnt}
                + {{(AW+1){1'b0}}, head_vld}
                - {{(AW+1){1'b0}}, pop};
    assign room = occ <= (AW+2)'(FIFO_DEPTH - ROWS);

    assign is_fp = mode_q inside {2'b10, 2'b11};
    assign row   = ROWS_M1 - cnt;
    assign entry = {fmt, row, (row == '0)};

`ifdef PE_COL_DRAIN_SAT_EN
    localparam int XW = IN_WIDTH + OUT_WIDTH;
    localparam logic signed [XW-1:0] SMAX =
        {{(IN_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] SMIN = ~SMAX;

    logic signed [XW-1:0] sx;

    always_comb begin
        sx      = {{OUT_WIDTH{col_in[IN_WIDTH-1]}}, col_in};
        sx      = sx >>> SHIFT;
        sat_hit = 1'b0;
        fmt     = sx[OUT_WIDTH-1:0];
        if (is_fp) begin
            fmt = OUT_WIDTH'(col_in);
        end else if (sx > SMAX) begin
            fmt     = SMAX[OUT_WIDTH-1:0];
            sat_hit = 1'b1;
        end else if (sx < SMIN) begin
            fmt     = SMIN[OUT_WIDTH-1:0];
            sat_hit = 1'b1;
        end
    end
`else
    always_comb begin
        sat_hit = 1'b0;
        if (is_fp)
            fmt = OUT_WIDTH'(col_in);
        else
            fmt = OUT_WIDTH'($signed(col_in) >>> SHIFT);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            drain_gnt_out <= 1'b0;
            cnt           <= '0;
            mode_q        <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (drain_req_in && room) begin
                        state         <= GRANT;
                        drain_gnt_out <= 1'b1;
                    end
                end
                GRANT: begin
                    drain_gnt_out <= 1'b0;
                    mode_q        <= mode_sel_in;
                    cnt           <= '0;
                    state         <= COLLECT;
                end
                COLLECT: begin
                    if (col_vld_in) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == ROWS_M1)
                            state <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    drain_gnt_out <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            head_vld <= 1'b0;
            head     <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (load) begin
                head     <= mem[rd_ptr[AW-1:0]];
                rd_ptr   <= rd_ptr + 1'b1;
                head_vld <= 1'b1;
            end else if (pop) begin
                head_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_out <= 1'b0;
        else
            err_out <= stray | (push & sat_hit) | (err_out & ~err_clr_in);
    end

    assign dn.m_valid = head_vld;
    assign {dn.m_data, dn.m_row, dn.m_last} = head;

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && (mem_cnt == (AW+1)'(FIFO_DEPTH)))
    );
endmodule

// File: tb/tb_pe_col_drain.sv
// Bench for pe_col_drain: two instances (SHIFT 0 and 4) on shared stimulus.
module tb_pe_col_drain;
    localparam int ROWS = 16;
    localparam int OW   = 32;

`ifdef PE_COL_DRAIN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  r;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        req, vld, clr, ready;
    logic [47:0] col;
    logic        gnt0, gnt4, err0, err4;

    exp_t q0[$];
    exp_t q4[$];
    exp_t e0, e4;
    bit   eerr0, eerr4;
    bit   rand_ready;
    int   tests, fails;

    always #5 clk = ~clk;

    pe_col_drain_if #(.OUT_WIDTH(OW), .ROWS(ROWS)) if0 ();
    pe_col_drain_if #(.OUT_WIDTH(OW), .ROWS(ROWS)) if4 ();

    assign if0.m_ready = ready;
    assign if4.m_ready = ready;

    pe_col_drain #(.SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mode_sel_in(mode),
        .drain_req_in(req), .drain_gnt_out(gnt0),
        .col_vld_in(vld), .col_in(col),
        .err_out(err0), .err_clr_in(clr), .dn(if0.master)
    );

    pe_col_drain #(.SHIFT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode_sel_in(mode),
        .drain_req_in(req), .drain_gnt_out(gnt4),
        .col_vld_in(vld), .col_in(col),
        .err_out(err4), .err_clr_in(clr), .dn(if4.master)
    );

    // Reference formatting from the arithmetic rules, on 64-bit integers.
    function automatic exp_t model(input logic [1:0] md, input logic [47:0] c,
                                   input int s, input int k, output bit sat);
        longint v, mx, mn;
        exp_t   e;
        sat = 1'b0;
        mx  = (longint'(1) <<< 31) - 1;
        mn  = -(longint'(1) <<< 31);
        v   = longint'($signed(c)) >>> s;
        if (md[1])
            e.d = c[31:0];
        else if (SAT && v > mx) begin
            e.d = 32'h7fff_ffff;
            sat = 1'b1;
        end else if (SAT && v < mn) begin
            e.d = 32'h8000_0000;
            sat = 1'b1;
        end else
            e.d = v[31:0];
        e.r = 4'(ROWS - 1 - k);
        e.l = (k == ROWS - 1);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ready) begin
            if (if0.m_valid) begin
                tests++;
                if (q0.size() == 0) begin
                    fails++;
                    $display("FAIL sb0_extra got d=%h r=%0d", if0.m_data, if0.m_row);
                end else begin
                    e0 = q0.pop_front();
                    if ({if0.m_data, if0.m_row, if0.m_last} !== e0) begin
                        fails++;
                        $display("FAIL sb0 got d=%h r=%0d l=%b exp d=%h r=%0d l=%b",
                                 if0.m_data, if0.m_row, if0.m_last, e0.d, e0.r, e0.l);
                    end
                end
            end
            if (if4.m_valid) begin
                tests++;
                if (q4.size() == 0) begin
                    fails++;
                    $display("FAIL sb4_extra got d=%h r=%0d", if4.m_data, if4.m_row);
                end else begin
                    e4 = q4.pop_front();
                    if ({if4.m_data, if4.m_row, if4.m_last} !== e4) begin
                        fails++;
                        $display("FAIL sb4 got d=%h r=%0d l=%b exp d=%h r=%0d l=%b",
                                 if4.m_data, if4.m_row, if4.m_last, e4.d, e4.r, e4.l);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_ready)
            ready = 1'($urandom_range(0, 1));
    endtask

    // kind 0: values 1..ROWS; kind 1: v0, v1, then random.
    task automatic do_drain(input logic [1:0] md, input int kind,
                            input logic [47:0] v0, input logic [47:0] v1,
                            input int gap, input bit lat, output int waited);
        logic [63:0] r;
        logic [47:0] c;
        bit          s;
        mode   = md;
        req    = 1'b1;
        waited = 0;
        do begin
            cyc();
            waited++;
        end while (!gnt0 && waited < 300);
        tests++;
        if (gnt0 !== 1'b1 || gnt4 !== 1'b1) begin
            fails++;
            $display("FAIL drain_gnt got %b/%b want 1 after %0d cycles",
                     gnt0, gnt4, waited);
            req = 1'b0;
            return;
        end
        req = 1'b0;
        cyc();
        tests++;
        if (gnt0 !== 1'b0 || gnt4 !== 1'b0) begin
            fails++;
            $display("FAIL gnt_pulse got %b/%b want 0", gnt0, gnt4);
        end
        for (int k = 0; k < ROWS; k++) begin
            while (gap > 0 && $urandom_range(0, 99) < gap) begin
                vld = 1'b0;
                cyc();
            end
            r = {$urandom, $urandom};
            if (kind == 0)      c = 48'(k + 1);
            else if (k == 0)    c = v0;
            else if (k == 1)    c = v1;
            else                c = r[47:0];
            vld = 1'b1;
            col = c;
            q0.push_back(model(md, c, 0, k, s));
            eerr0 |= s;
            q4.push_back(model(md, c, 4, k, s));
            eerr4 |= s;
            cyc();
            if (lat && k < 2) begin
                tests++;
                if (if0.m_valid !== (k == 1)) begin
                    fails++;
                    $display("FAIL latency beat%0d got m_valid=%b want %b",
                             k, if0.m_valid, (k == 1));
                end
            end
        end
        vld = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((q0.size() != 0 || q4.size() != 0 || if0.m_valid || if4.m_valid)
               && n < 2000) begin
            cyc();
            n++;
        end
        tests++;
        if (q0.size() != 0 || q4.size() != 0 || if0.m_valid || if4.m_valid) begin
            fails++;
            $display("FAIL drain_timeout left %0d/%0d entries", q0.size(), q4.size());
        end
    endtask

    task automatic check_err(input string name);
        tests++;
        if (err0 !== eerr0 || err4 !== eerr4) begin
            fails++;
            $display("FAIL %s got err=%b/%b want %b/%b", name, err0, err4, eerr0, eerr4);
        end
    endtask

    task automatic clear_err();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        eerr0 = 1'b0;
        eerr4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode = 2'b00; req = 1'b0; vld = 1'b0; clr = 1'b0;
        col = '0; ready = 1'b1; rand_ready = 1'b0;
        #12;
        tests++;
        if ({gnt0, err0, if0.m_valid, if0.m_data, if0.m_row, if0.m_last} !== '0) begin
            fails++;
            $display("FAIL reset got gnt=%b err=%b v=%b d=%h r=%0d l=%b want 0",
                     gnt0, err0, if0.m_valid, if0.m_data, if0.m_row, if0.m_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        int w;
        ready = 1'b1;
        do_drain(2'b00, 0, '0, '0, 0, 1'b1, w);
        tests++;
        if (w != 1) begin
            fails++;
            $display("FAIL basic_grant got %0d cycles want 1", w);
        end
        wait_empty();
        check_err("basic_err");
    endtask

    task automatic test_backpressure();
        int w;
        int ng = 0;
        ready = 1'b0;
        do_drain(2'b00, 1, 48'h1234_5678_9abc, 48'h0000_0000_0042, 0, 1'b0, w);
        for (int i = 0; i < 20; i++) begin
            cyc();
            tests++;
            if (if0.m_valid !== 1'b1 || {if0.m_data, if0.m_row, if0.m_last} !== q0[0]) begin
                fails++;
                $display("FAIL bp_stable got v=%b d=%h r=%0d want d=%h r=%0d",
                         if0.m_valid, if0.m_data, if0.m_row, q0[0].d, q0[0].r);
            end
        end
        do_drain(2'b00, 1, 48'h0, 48'h1, 10, 1'b0, w);
        tests++;
        if (w != 1) begin
            fails++;
            $display("FAIL bp_second_grant got %0d cycles want 1", w);
        end
        mode = 2'b00;
        req  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (gnt0 || gnt4) ng++;
        end
        tests++;
        if (ng != 0) begin
            fails++;
            $display("FAIL bp_third_held got %0d grants want 0", ng);
        end
        rand_ready = 1'b1;
        do_drain(2'b00, 1, 48'h5, 48'h6, 0, 1'b0, w);
        wait_empty();
        rand_ready = 1'b0;
        ready = 1'b1;
        check_err("bp_err");
    endtask

    task automatic test_narrow();
        int w;
        clear_err();
        ready = 1'b0;
        do_drain(2'b00, 1, 48'h0000_0012_3450, 48'h7fff_ffff_ffff, 30, 1'b0, w);
        cyc();
        tests++;
        if (if4.m_data !== 32'h0001_2345 || if0.m_data !== 32'h0012_3450) begin
            fails++;
            $display("FAIL narrow_shift got %h/%h want 00123450/00012345",
                     if0.m_data, if4.m_data);
        end
        rand_ready = 1'b1;
        wait_empty();
        rand_ready = 1'b0;
        ready = 1'b1;
        check_err("narrow_err");
    endtask

    task automatic test_fp();
        int w;
        clear_err();
        ready = 1'b0;
        do_drain(2'b11, 1, 48'h0007_f2a5_1234, 48'hffff_8000_0001, 0, 1'b0, w);
        cyc();
        tests++;
        if (if0.m_data !== 32'hf2a5_1234 || if4.m_data !== 32'hf2a5_1234) begin
            fails++;
            $display("FAIL fp_pass got %h/%h want f2a51234", if0.m_data, if4.m_data);
        end
        ready = 1'b1;
        wait_empty();
        do_drain(2'b10, 1, 48'h8000_0000_0000, 48'h7fff_ffff_ffff, 20, 1'b0, w);
        wait_empty();
        check_err("fp_err");
    endtask

    task automatic test_stray();
        vld = 1'b1;
        col = 48'h0000_dead_beef;
        cyc();
        vld = 1'b0;
        cyc();
        eerr0 = 1'b1;
        eerr4 = 1'b1;
        check_err("stray_err_set");
        tests++;
        if (if0.m_valid !== 1'b0 || if4.m_valid !== 1'b0) begin
            fails++;
            $display("FAIL stray_push got m_valid=%b/%b want 0", if0.m_valid, if4.m_valid);
        end
        clear_err();
        check_err("stray_err_clr");
        vld = 1'b1;
        clr = 1'b1;
        cyc();
        vld = 1'b0;
        clr = 1'b0;
        eerr0 = 1'b1;
        eerr4 = 1'b1;
        check_err("stray_set_priority");
        clear_err();
    endtask

    task automatic test_random();
        int w;
        rand_ready = 1'b1;
        for (int i = 0; i < 6; i++)
            do_drain(2'($urandom_range(0, 3)), 1, 48'h0000_ffff_ffff,
                     48'hffff_0000_0000, 20, 1'b0, w);
        wait_empty();
        rand_ready = 1'b0;
        ready = 1'b1;
        check_err("random_err");
    endtask

    task automatic test_reset_mid();
        int w = 0;
        int nv = 0;
        ready = 1'b1;
        mode  = 2'b00;
        req   = 1'b1;
        do begin
            cyc();
            w++;
        end while (!gnt0 && w < 300);
        req = 1'b0;
        cyc();
        for (int k = 0; k < 7; k++) begin
            bit s;
            vld = 1'b1;
            col = 48'(100 + k);
            q0.push_back(model(2'b00, col, 0, k, s));
            q4.push_back(model(2'b00, col, 4, k, s));
            cyc();
        end
        #2;
        rst_n = 1'b0;
        vld   = 1'b0;
        #1;
        tests++;
        if ({gnt0, err0, if0.m_valid, if0.m_data, if0.m_row, if0.m_last,
             gnt4, err4, if4.m_valid} !== '0) begin
            fails++;
            $display("FAIL reset_mid got gnt=%b err=%b v=%b d=%h want 0",
                     gnt0, err0, if0.m_valid, if0.m_data);
        end
        q0.delete();
        q4.delete();
        eerr0 = 1'b0;
        eerr4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (if0.m_valid || if4.m_valid) nv++;
        end
        tests++;
        if (nv != 0) begin
            fails++;
            $display("FAIL reset_flush got %0d valid cycles want 0", nv);
        end
        do_drain(2'b00, 0, '0, '0, 0, 1'b0, w);
        wait_empty();
        check_err("reset_mid_err");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        eerr0 = 1'b0;
        eerr4 = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_narrow();
        test_fp();
        test_stray();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
